// File: rtl/video_timing_pkg.sv
// Shared types and default 1080p60 timing for the video timing generator.
package video_timing_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } timing_t;

    localparam int unsigned H_ACTIVE_1080P = 1920;
    localparam int unsigned H_FRONT_1080P  = 88;
    localparam int unsigned H_SYNC_1080P   = 44;
    localparam int unsigned H_BACK_1080P   = 148;
    localparam int unsigned V_ACTIVE_1080P = 1080;
    localparam int unsigned V_FRONT_1080P  = 4;
    localparam int unsigned V_SYNC_1080P   = 5;
    localparam int unsigned V_BACK_1080P   = 36;

    function automatic int unsigned total(timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter plus active/front/sync/back phase FSM.
// pos and phase are the next-state values so the top can register outputs in step with them.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter timing_t TIMING = '{active: H_ACTIVE_1080P, front: H_FRONT_1080P,
                                  sync: H_SYNC_1080P, back: H_BACK_1080P},
    localparam int unsigned TOTAL = total(TIMING),
    localparam int unsigned W = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] pos,
    output phase_e       phase,
    output logic         wrap
);

    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] cnt_q, cnt_d;
    phase_e       phase_q, phase_d;

    function automatic logic [W-1:0] last_count(phase_e ph);
        unique case (ph)
            PH_ACTIVE: return W'(TIMING.active - 1);
            PH_FRONT:  return W'(TIMING.front - 1);
            PH_SYNC:   return W'(TIMING.sync - 1);
            default:   return W'(TIMING.back - 1);
        endcase
    endfunction

    assign wrap = advance && (pos_q == W'(TOTAL - 1));

    always_comb begin
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            pos_d   = '0;
            phase_d = PH_ACTIVE;
            cnt_d   = last_count(PH_ACTIVE);
        end else if (advance) begin
            pos_d = wrap ? '0 : pos_q + 1'b1;
            if (cnt_q == '0) begin
                // Enum order matches raster order, so back wraps to active.
                phase_d = phase_e'(phase_q + 2'd1);
                cnt_d   = last_count(phase_e'(phase_q + 2'd1));
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            phase_q <= PH_ACTIVE;
            cnt_q   <= last_count(PH_ACTIVE);
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pos   = pos_d;
    assign phase = phase_d;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: hsync/vsync/rgb_de and active-area coordinates, all registered
// from the next-position decode so every output describes the same (h, v).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_1080P,
    parameter int unsigned H_FRONT   = H_FRONT_1080P,
    parameter int unsigned H_SYNC    = H_SYNC_1080P,
    parameter int unsigned H_BACK    = H_BACK_1080P,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_1080P,
    parameter int unsigned V_FRONT   = V_FRONT_1080P,
    parameter int unsigned V_SYNC    = V_SYNC_1080P,
    parameter int unsigned V_BACK    = V_BACK_1080P,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    localparam int unsigned XW = $clog2(H_ACTIVE) + 1,
    localparam int unsigned YW = $clog2(V_ACTIVE) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          rgb_de,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam timing_t H_TIMING = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam timing_t V_TIMING = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned HW = $clog2(total(H_TIMING));
    localparam int unsigned VW = $clog2(total(V_TIMING));

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_param_check
        $error("video_timing_gen: every timing parameter must be >= 1");
    end

    logic          running_q;
    logic          clear;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    phase_e        h_phase, v_phase;
    logic          h_wrap, v_wrap;

    logic          hsync_d, vsync_d, rgb_de_d, line_start_d, frame_start_d;
    logic [XW-1:0] pixel_x_d;
    logic [YW-1:0] pixel_y_d;

    // The first enabled edge after idle loads (0,0) instead of advancing.
    assign clear = !enable || !running_q;

    timing_axis_counter #(.TIMING(H_TIMING)) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (enable),
        .pos     (h_next),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    timing_axis_counter #(.TIMING(V_TIMING)) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (h_wrap),
        .pos     (v_next),
        .phase   (v_phase),
        .wrap    (v_wrap)
    );

    always_comb begin
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        rgb_de_d      = 1'b0;
        pixel_x_d     = '0;
        pixel_y_d     = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            rgb_de_d      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            hsync_d       = (h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = !running_q || h_wrap;
            frame_start_d = !running_q || v_wrap;
            if (rgb_de_d) begin
                pixel_x_d = XW'(h_next);
                pixel_y_d = YW'(v_next);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q   <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            rgb_de      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running_q   <= enable;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            rgb_de      <= rgb_de_d;
            pixel_x     <= pixel_x_d;
            pixel_y     <= pixel_y_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on a small 8x6 raster, with an active-high and an active-low sync instance.
module tb_video_timing_gen;

    localparam int XW = $clog2(4) + 1;
    localparam int YW = $clog2(3) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          hsync, vsync, rgb_de, line_start, frame_start;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          hsync_n, vsync_n, rgb_de_n, line_start_n, frame_start_n;
    logic [XW-1:0] pixel_x_n;
    logic [YW-1:0] pixel_y_n;

    int vectors = 0;
    int fails   = 0;
    int fs_cnt, ls_cnt, de_cnt, vs_cnt, vsn_cnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .hsync(hsync), .vsync(vsync),
        .rgb_de(rgb_de), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .enable(enable), .hsync(hsync_n), .vsync(vsync_n),
        .rgb_de(rgb_de_n), .pixel_x(pixel_x_n), .pixel_y(pixel_y_n),
        .line_start(line_start_n), .frame_start(frame_start_n)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @k=%0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at raster index k (k=0 is the first enabled cycle), H_TOTAL=8, V_TOTAL=6.
    task automatic check_pos(input int k);
        int h, v;
        logic de;
        h  = k % 8;
        v  = (k / 8) % 6;
        de = (h < 4) && (v < 3);
        chk("rgb_de", k, rgb_de, de);
        chk("pixel_x", k, pixel_x, de ? h : 0);
        chk("pixel_y", k, pixel_y, de ? v : 0);
        chk("hsync", k, hsync, (h == 5 || h == 6));
        chk("vsync", k, vsync, (v == 4));
        chk("line_start", k, line_start, (h == 0));
        chk("frame_start", k, frame_start, (h == 0 && v == 0));
        chk("hsync_n", k, hsync_n, !(h == 5 || h == 6));
        chk("vsync_n", k, vsync_n, !(v == 4));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rgb_de"}, -1, rgb_de, 0);
        chk({tag, "_pixel_x"}, -1, pixel_x, 0);
        chk({tag, "_pixel_y"}, -1, pixel_y, 0);
        chk({tag, "_hsync"}, -1, hsync, 0);
        chk({tag, "_vsync"}, -1, vsync, 0);
        chk({tag, "_line_start"}, -1, line_start, 0);
        chk({tag, "_frame_start"}, -1, frame_start, 0);
        chk({tag, "_hsync_n"}, -1, hsync_n, 1);
        chk({tag, "_vsync_n"}, -1, vsync_n, 1);
        chk({tag, "_rgb_de_n"}, -1, rgb_de_n, 0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) step();
        check_idle("reset");

        // Start and free run for three frames.
        rst    = 1'b0;
        enable = 1'b1;
        fs_cnt = 0; ls_cnt = 0; de_cnt = 0; vs_cnt = 0; vsn_cnt = 0;
        for (int n = 0; n < 144; n++) begin
            step();
            check_pos(n);
            fs_cnt  += int'(frame_start);
            ls_cnt  += int'(line_start);
            de_cnt  += int'(rgb_de);
            vs_cnt  += int'(vsync);
            vsn_cnt += int'(!vsync_n);
        end
        chk("frames_in_144", -1, fs_cnt, 3);
        chk("lines_in_144", -1, ls_cnt, 18);
        chk("de_in_144", -1, de_cnt, 36);
        chk("vsync_in_144", -1, vs_cnt, 24);
        chk("vsync_n_in_144", -1, vsn_cnt, 24);

        // Run on to h=2, v=1, then drop enable.
        for (int n = 144; n <= 154; n++) begin
            step();
            check_pos(n);
        end
        enable = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check_idle("drop");
        end

        // Re-enable always begins a fresh frame.
        enable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            check_pos(n);
        end

        // Asynchronous reset mid-line with rgb_de high (k=9: h=1, v=1).
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        #1;
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            check_pos(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates a continuous raster of video timing: hsync, vsync, rgb_de, plus pixel_x/pixel_y for the active area. All timing is fixed at elaboration.
It is the source-side counterpart to the HDMI-input timing path. It drives test patterns and internal frames into the matrix processing chain.
Its outputs can be looped back into the resolution-detection logic for self-test.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FRONT, 88, horizontal front porch (clocks)
H_SYNC, 44, hsync pulse width (clocks)
H_BACK, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, active lines per frame
V_FRONT, 4, vertical front porch (lines)
V_SYNC, 5, vsync pulse width (lines)
V_BACK, 36, vertical back porch (lines)
HSYNC_POL, 1, asserted level of hsync (1 = active-high)
VSYNC_POL, 1, asserted level of vsync

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run timing; low = idle
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
rgb_de  out  1  data enable, high only in active area
pixel_x  out  $clog2(H_ACTIVE)+1  x position in active area, 0 outside it
pixel_y  out  $clog2(V_ACTIVE)+1  y position in active area, 0 outside it
line_start  out  1  1-cycle pulse at h=0 of every line (including blanking lines)
frame_start  out  1  1-cycle pulse at h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is formed the same way. Every parameter must be ≥1, enforced by an elaboration-time assertion.
- Internal position h ∈ [0,H_TOTAL), v ∈ [0,V_TOTAL). Widths are $clog2(total); no overflow is possible.
- Horizontal phase FSM: HA → HFP → HS → HBP → HA. Phases are ordered active, front, sync, back. The vertical FSM uses the same order and advances only on the h wrap.
- Each phase is tracked by a phase counter that reloads on phase change.
- Running:
  - h increments every clk.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 with h wrapping, v wraps to 0.
- Decode:
  - rgb_de = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hsync asserted for h ∈ [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync asserted for whole lines v ∈ [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), aligned to h=0.
- Deasserted sync level = ~POL.
- All outputs are registered. They are updated on the same edge as the position, from the next-position decode, so every output always describes the same (h,v).
- Start latency: on the first edge at which enable=1 from idle, position loads (0,0). Immediately after that edge: frame_start=1, line_start=1, rgb_de=1, pixel_x=0, pixel_y=0.
- enable low, sampled at an edge: next state is idle. Position = (0,0) held; outputs take their reset values.
- Re-enable always starts a fresh frame. A mid-frame drop never resumes.
- Reset values (also idle values): hsync=~HSYNC_POL, vsync=~VSYNC_POL, rgb_de=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
- rst is asynchronous. Outputs go to reset values immediately, without a clock edge, including mid-frame.
- Simultaneous h and v wrap: frame_start and line_start pulse together. Exactly one frame_start per V_TOTAL*H_TOTAL clocks.

Decomposition:
- Package video_timing_pkg:
  - phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK};
  - timing struct typedef {active, front, sync, back};
  - 1080p60 default constants;
  - a total() helper function.
- Sub-module timing_axis_counter (inputs: advance, the timing struct; outputs: pos, phase, wrap). It is instantiated twice:
  - horizontal, with advance=enable;
  - vertical, with advance=h wrap.
- The top level does the decode and output registers.

Test Plan:
- Small timing (H 4/1/2/1 → H_TOTAL=8; V 3/1/1/1 → V_TOTAL=6). Release rst, enable=1. Required response:
  - first cycle after the edge: frame_start=1, rgb_de=1, x=0, y=0;
  - rgb_de high for 4 clocks with x=0..3, then low 4 clocks;
  - hsync asserted at h=5,6.
- Same config, free run for 3 frames:
  - frame_start period = 48 clocks; line_start period = 8 clocks;
  - 12 rgb_de cycles per frame, with y=0,1,2;
  - vsync asserted for exactly the 8 clocks of line v=4.
- HSYNC_POL=0, VSYNC_POL=0: under reset hsync=vsync=1; hsync low only at h=5,6; vsync low only during v=4.
- Drop enable at h=2, v=1. Required response:
  - next cycle rgb_de=0 and syncs inactive, then held;
  - after re-enable, the first cycle shows frame_start=1, x=0, y=0.
- Assert rst asynchronously mid-line while rgb_de=1 → all outputs at reset values before the next clk edge. After release and enable, normal start as in test 1.
- Default 1080p params: 2,475,000 clocks between frame_start pulses; 2,073,600 rgb_de cycles per frame; loopback detection reports 1920 pixels/line and 1080 lines.
